// File: rtl/ins_mem_loader.sv
// Program loader: parses a framed byte stream, writes big-endian words to instruction
// memory and releases the CPU from reset once the payload checksum has verified.
module ins_mem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_in,
    output logic              o_byte_ready,
    output logic              o_ins_wr,
    output logic [ADDR_W-1:0] o_ins_addr,
    output logic [31:0]       o_ins_data,
    output logic              o_cpu_nreset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned IDX_W     = ADDR_W - 2;
    localparam int unsigned MAX_WORDS = 2 ** IDX_W;
    localparam logic [7:0]  SYNC      = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_byte_ready;
    logic               r_ins_wr;
    logic [ADDR_W-1:0]  r_ins_addr;
    logic [31:0]        r_ins_data;
    logic               r_cpu_nreset;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [7:0]         r_len_hi;
    logic [15:0]        r_len;
    logic [23:0]        r_asm;
    logic [1:0]         r_byte_cnt;
    logic [IDX_W-1:0]   r_word_idx;
    logic [7:0]         r_xor;

    logic               w_xfer;
    logic [15:0]        w_new_len;
    logic               w_len_ok;
    logic               w_word_done;
    logic               w_last_word;

    assign w_xfer      = i_byte_valid & r_byte_ready;
    assign w_new_len   = {r_len_hi, i_byte_in};
    assign w_len_ok    = (w_new_len != 16'd0) && (32'(w_new_len) <= MAX_WORDS);
    assign w_word_done = w_xfer && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
    assign w_last_word = (16'(r_word_idx) == (r_len - 16'd1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_xfer && (i_byte_in == SYNC)) w_next_state = S_LEN_HI;
            S_LEN_HI: if (w_xfer) w_next_state = S_LEN_LO;
            S_LEN_LO: if (w_xfer) w_next_state = w_len_ok ? S_DATA : S_ERR;
            S_DATA:   if (w_word_done && w_last_word) w_next_state = S_CHK;
            S_CHK:    if (w_xfer) w_next_state = (i_byte_in == r_xor) ? S_RUN : S_ERR;
            S_RUN:    w_next_state = S_RUN;
            S_ERR:    if (w_xfer && (i_byte_in == SYNC)) w_next_state = S_LEN_HI;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Status outputs registered from the upcoming state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_ready <= 1'b1;
            r_cpu_nreset <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ins_wr     <= 1'b0;
        end else begin
            r_byte_ready <= (w_next_state != S_RUN);
            r_cpu_nreset <= (w_next_state == S_RUN);
            r_done       <= (w_next_state == S_RUN);
            r_err        <= (w_next_state == S_ERR);
            r_busy       <= (w_next_state == S_LEN_HI) || (w_next_state == S_LEN_LO) ||
                            (w_next_state == S_DATA)   || (w_next_state == S_CHK);
            r_ins_wr     <= w_word_done;
        end
    end

    // Length capture, word assembly, checksum and write port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len_hi   <= 8'd0;
            r_len      <= 16'd0;
            r_asm      <= 24'd0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
            r_xor      <= 8'd0;
            r_ins_addr <= '0;
            r_ins_data <= 32'd0;
        end else if (w_xfer) begin
            case (r_state)
                S_LEN_HI: r_len_hi <= i_byte_in;
                S_LEN_LO: begin
                    r_len      <= w_new_len;
                    r_byte_cnt <= 2'd0;
                    r_word_idx <= '0;
                    r_xor      <= 8'd0;
                end
                S_DATA: begin
                    r_asm      <= {r_asm[15:0], i_byte_in};
                    r_xor      <= r_xor ^ i_byte_in;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        r_ins_addr <= {r_word_idx, 2'b00};
                        r_ins_data <= {r_asm, i_byte_in};
                        r_word_idx <= r_word_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_ins_wr     = r_ins_wr;
    assign o_ins_addr   = r_ins_addr;
    assign o_ins_data   = r_ins_data;
    assign o_cpu_nreset = r_cpu_nreset;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: expected memory writes are queued as words
// are streamed and popped when the write strobe is observed.
module tb_ins_mem_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic              byte_ready;
    logic              ins_wr;
    logic [ADDR_W-1:0] ins_addr;
    logic [31:0]       ins_data;
    logic              cpu_nreset;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [39:0] exp_wr_q[$];
    logic [31:0] frame_words[$];

    ins_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_byte_valid (byte_valid),
        .i_byte_in    (byte_in),
        .o_byte_ready (byte_ready),
        .o_ins_wr     (ins_wr),
        .o_ins_addr   (ins_addr),
        .o_ins_data   (ins_data),
        .o_cpu_nreset (cpu_nreset),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: every observed write must match the oldest expected write
    always @(negedge clk) begin
        if (ins_wr === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_wr", {24'd0, ins_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = exp_wr_q.pop_front();
                check("wr_addr", {24'd0, ins_addr}, {24'd0, e[39:32]});
                check("wr_data", ins_data, e[31:0]);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_ready",  {31'd0, byte_ready}, 32'd1);
        check("rst_wr",     {31'd0, ins_wr},     32'd0);
        check("rst_addr",   {24'd0, ins_addr},   32'd0);
        check("rst_data",   ins_data,            32'd0);
        check("rst_nreset", {31'd0, cpu_nreset}, 32'd0);
        check("rst_busy",   {31'd0, busy},       32'd0);
        check("rst_done",   {31'd0, done},       32'd0);
        check("rst_err",    {31'd0, err},        32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge
    task automatic send(input logic [7:0] b, input int gap);
        int t = 0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (byte_ready !== 1'b1) begin
            check("ready_timeout", 32'd0, 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        byte_valid = 1'b0;
    endtask

    // Streams frame_words[0..n-1]; checksum computed here unless corrupted
    task automatic send_frame(input int n, input bit bad_chk, input int max_gap);
        logic [15:0] n16;
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        n16 = 16'(n);
        x   = 8'd0;
        send(8'hA5, $urandom_range(0, max_gap));
        check("sync_busy", {31'd0, busy}, 32'd1);
        check("sync_err",  {31'd0, err},  32'd0);
        send(n16[15:8], $urandom_range(0, max_gap));
        send(n16[7:0],  $urandom_range(0, max_gap));
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            for (int j = 0; j < 4; j++) begin
                b = w[31-8*j -: 8];
                x = x ^ b;
                if (j == 3) exp_wr_q.push_back({8'(i * 4), w});
                send(b, $urandom_range(0, max_gap));
                if (j == 3) check("wr_pulse", {31'd0, ins_wr}, 32'd1);
                else        check("data_busy", {31'd0, busy}, 32'd1);
            end
        end
        send(bad_chk ? (x ^ 8'h01) : x, $urandom_range(0, max_gap));
        idle();
        check("end_wr_low", {31'd0, ins_wr}, 32'd0);
        check("end_busy",   {31'd0, busy},   32'd0);
        check("end_done",   {31'd0, done},   bad_chk ? 32'd0 : 32'd1);
        check("end_nreset", {31'd0, cpu_nreset}, bad_chk ? 32'd0 : 32'd1);
        check("end_err",    {31'd0, err},    bad_chk ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'd0;
        do_reset();

        // Junk before sync is dropped, then the single-word program
        send(8'h00, 0);
        send(8'hFF, 0);
        send(8'h5A, 0);
        idle();
        check("junk_busy", {31'd0, busy}, 32'd0);
        check("junk_err",  {31'd0, err},  32'd0);
        check("junk_wr",   {31'd0, ins_wr}, 32'd0);
        frame_words = {32'h2001_0005};
        send_frame(1, 1'b0, 0);

        // Loaded: further bytes are refused and the CPU keeps running
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("run_ready",  {31'd0, byte_ready}, 32'd0);
            check("run_nreset", {31'd0, cpu_nreset}, 32'd1);
        end
        idle();
        check("sb_empty_1", exp_wr_q.size(), 32'd0);

        // Two words with random idle gaps
        do_reset();
        frame_words = {32'h1122_3344, 32'hAABB_CCDD};
        send_frame(2, 1'b0, 3);
        check("sb_empty_2", exp_wr_q.size(), 32'd0);

        // Bad checksum rejects, then a good resend recovers
        do_reset();
        frame_words = {32'h2001_0005};
        send_frame(1, 1'b1, 0);
        frame_words = {32'h2001_0005};
        send_frame(1, 1'b0, 1);
        check("sb_empty_3", exp_wr_q.size(), 32'd0);

        // Length bounds: 65 and 0 rejected, 64 accepted
        do_reset();
        send(8'hA5, 0); send(8'h00, 0); send(8'h41, 0);
        idle();
        check("len41_err",  {31'd0, err},  32'd1);
        check("len41_busy", {31'd0, busy}, 32'd0);
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
        idle();
        check("len0_err", {31'd0, err}, 32'd1);
        frame_words.delete();
        for (int i = 0; i < 64; i++) frame_words.push_back($urandom());
        send_frame(64, 1'b0, 0);
        check("sb_empty_4", exp_wr_q.size(), 32'd0);

        // Reset mid-DATA overrides a handshake, then a fresh load
        do_reset();
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
        send(8'hDE, 0); send(8'hAD, 0);
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hBE;
        @(negedge clk);
        rst = 1'b0;
        idle();
        check_reset_values();
        frame_words = {32'hDEAD_BEEF};
        send_frame(1, 1'b0, 2);
        repeat (3) @(negedge clk);
        check("sb_empty_5", exp_wr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
